// File: rtl/arbitro_serial_if.sv
// arbitro_serial_if
// Handshake/bus bundle of the two-sender serial arbiter.
//   master : sender A/B request and bit lines, deserializer ready/byte,
//            downstream accept; observes grants, deserializer strobes,
//            ack and the captured byte.
//   slave  : the arbiter side (arbitro_serial).
// Signals:
//   req_a/req_b, data_a/data_b, write_a/write_b : sender requests and bits
//   grant_a/grant_b                             : ownership of deserializer
//   des_data_in/des_write_in                    : serial bit + strobe out
//   des_data_ready/des_data/des_ack             : deserializer handshake
//   byte_out/src_out/byte_valid/byte_accept     : captured byte to downstream
//   busy                                        : arbiter not idle
interface arbitro_serial_if;
    logic       req_a;
    logic       req_b;
    logic       data_a;
    logic       data_b;
    logic       write_a;
    logic       write_b;
    logic       grant_a;
    logic       grant_b;
    logic       des_data_in;
    logic       des_write_in;
    logic       des_data_ready;
    logic [7:0] des_data;
    logic       des_ack;
    logic [7:0] byte_out;
    logic       src_out;
    logic       byte_valid;
    logic       byte_accept;
    logic       busy;

    modport master (
        output req_a, req_b, data_a, data_b, write_a, write_b,
        output des_data_ready, des_data, byte_accept,
        input  grant_a, grant_b, des_data_in, des_write_in, des_ack,
        input  byte_out, src_out, byte_valid, busy
    );

    modport slave (
        input  req_a, req_b, data_a, data_b, write_a, write_b,
        input  des_data_ready, des_data, byte_accept,
        output grant_a, grant_b, des_data_in, des_write_in, des_ack,
        output byte_out, src_out, byte_valid, busy
    );
endinterface

// File: rtl/arbitro_serial.sv
// arbitro_serial
// Arbitrates two serial senders (A, B) onto one serial-to-byte
// deserializer. The winner owns the deserializer for exactly 8 bit
// strobes; the resulting byte is acknowledged for ACK_HOLD cycles, then
// presented downstream until byte_accept.
// Parameter:
//   ACK_HOLD : cycles des_ack stays high per byte (1..15), default 2.
// Ports:
//   clk_100KHz : sole clock
//   reset      : synchronous active-high reset
//   bus        : arbitro_serial_if.slave (see interface file)
// Configuration:
//   ARB_FIXED_PRIO_EN defined   -> A always wins a simultaneous request.
//   ARB_FIXED_PRIO_EN undefined -> round-robin, pointer resets to "last=B".
module arbitro_serial #(
    parameter int unsigned ACK_HOLD = 2
) (
    input  logic             clk_100KHz,
    input  logic             reset,
    arbitro_serial_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WAIT_READY,
        ACK,
        DRAIN,
        OUTPUT
    } state_t;

    localparam logic [3:0] ACK_HOLD_CNT = 4'(ACK_HOLD);

    state_t     state;
    state_t     next_state;
    logic [3:0] bit_cnt;
    logic [3:0] ack_cnt;
    logic       grant_a_q;
    logic       grant_b_q;
    logic       owner_b;
    logic       pend_a;
    logic       pend_b;
    logic       des_ack_q;
    logic [7:0] byte_out_q;
    logic       src_q;
    logic       valid_q;
    logic       des_write;
    logic       des_bit;
    logic       eff_a;
    logic       eff_b;
    logic       pick_b;
    logic       ack_done;
`ifndef ARB_FIXED_PRIO_EN
    logic       last_b;
`endif

    // A request seen outside IDLE is remembered so it is not lost
    assign eff_a    = bus.req_a | pend_a;
    assign eff_b    = bus.req_b | pend_b;
    assign ack_done = (ack_cnt == ACK_HOLD_CNT);

`ifdef ARB_FIXED_PRIO_EN
    assign pick_b = eff_b & ~eff_a;
`else
    // On a tie, B wins only if A was served last
    assign pick_b = eff_b & (~eff_a | ~last_b);
`endif

    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (eff_a | eff_b)                  next_state = COLLECT;
            COLLECT:    if (des_write && bit_cnt == 4'd7)   next_state = WAIT_READY;
            WAIT_READY: if (bus.des_data_ready)             next_state = ACK;
            ACK:        if (ack_done)                       next_state = DRAIN;
            DRAIN:      if (!bus.des_data_ready)            next_state = OUTPUT;
            OUTPUT:     if (bus.byte_accept)                next_state = IDLE;
            default:                                        next_state = IDLE;
        endcase
    end

    // Only the granted sender's lines reach the deserializer, and only
    // while collecting
    always_comb begin
        des_write = 1'b0;
        des_bit   = 1'b0;
        if (state == COLLECT) begin
            if (grant_a_q) begin
                des_write = bus.write_a;
                des_bit   = bus.data_a;
            end else if (grant_b_q) begin
                des_write = bus.write_b;
                des_bit   = bus.data_b;
            end
        end
    end

    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            grant_a_q  <= 1'b0;
            grant_b_q  <= 1'b0;
            owner_b    <= 1'b0;
            pend_a     <= 1'b0;
            pend_b     <= 1'b0;
            bit_cnt    <= 4'd0;
            ack_cnt    <= 4'd0;
            des_ack_q  <= 1'b0;
            byte_out_q <= 8'h00;
            src_q      <= 1'b0;
            valid_q    <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_b     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (eff_a | eff_b) begin
                        grant_a_q <= ~pick_b;
                        grant_b_q <= pick_b;
                        owner_b   <= pick_b;
                        bit_cnt   <= 4'd0;
                        // The loser keeps its request pending
                        pend_a    <= pick_b ? eff_a : 1'b0;
                        pend_b    <= pick_b ? 1'b0 : eff_b;
                    end
                end
                COLLECT: begin
                    if (des_write) begin
                        if (bit_cnt == 4'd7) begin
                            grant_a_q <= 1'b0;
                            grant_b_q <= 1'b0;
                            bit_cnt   <= 4'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                WAIT_READY: begin
                    if (bus.des_data_ready) begin
                        byte_out_q <= bus.des_data;
                        src_q      <= owner_b;
                        des_ack_q  <= 1'b1;
                        // The first ack cycle is counted on entry to ACK
                        ack_cnt    <= 4'd1;
                    end
                end
                ACK: begin
                    if (ack_done) begin
                        des_ack_q <= 1'b0;
                        ack_cnt   <= 4'd0;
                    end else begin
                        ack_cnt <= ack_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (!bus.des_data_ready) begin
                        valid_q <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (bus.byte_accept) begin
                        valid_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                        last_b  <= src_q;
`endif
                    end
                end
                default: ;
            endcase

            // Only the non-owner is latched while busy; the owner's own
            // request (still high right after its grant) must not re-queue it
            if (state != IDLE) begin
                if (owner_b) begin
                    pend_a <= pend_a | bus.req_a;
                end else begin
                    pend_b <= pend_b | bus.req_b;
                end
            end
        end
    end

    assign bus.grant_a      = grant_a_q;
    assign bus.grant_b      = grant_b_q;
    assign bus.des_data_in  = des_bit;
    assign bus.des_write_in = des_write;
    assign bus.des_ack      = des_ack_q;
    assign bus.byte_out     = byte_out_q;
    assign bus.src_out      = src_q;
    assign bus.byte_valid   = valid_q;
    assign bus.busy         = (state != IDLE);

endmodule

// File: doc/arbitro_serial.md
ARBITRO_SERIAL -- requirements
Module: arbitro_serial

Interface
REQ-001 Parameter: ACK_HOLD, default 2, number of cycles des_ack stays high per byte (legal 1..15).
REQ-002 Clock and reset SHALL be one clock and a synchronous, active-high reset, named clk_100KHz and reset.
REQ-003 Port list SHALL be:
- clk_100KHz  in  1  sole clock.
- reset  in  1  synchronous active-high reset.
- req_a, req_b  in  1 each  sender A/B requests to send one byte.
- data_a, data_b  in  1 each  serial data bit from sender A/B.
- write_a, write_b  in  1 each  bit-valid strobe from sender A/B.
- grant_a, grant_b  out  1 each  sender A/B owns the deserializer.
- des_data_in  out  1  serial bit to the serial-to-byte deserializer.
- des_write_in  out  1  bit strobe to the deserializer.
- des_data_ready  in  1  deserializer byte available.
- des_data  in  8  deserializer byte.
- des_ack  out  1  acknowledge to the deserializer.
- byte_out  out  8  captured byte.
- src_out  out  1  source of byte_out (0=A, 1=B).
- byte_valid  out  1  byte_out/src_out valid.
- byte_accept  in  1  downstream takes the byte.
- busy  out  1  high in any state except IDLE.

Function
REQ-004 FSM states SHALL be IDLE, COLLECT, WAIT_READY, ACK, DRAIN, OUTPUT.
REQ-005 IDLE: if any req is high, select a winner, register its grant, and go to COLLECT. Otherwise stay in IDLE.
REQ-006 With both req_a and req_b high in IDLE, the sender not served last SHALL win (round-robin). The pointer resets to "last=B", so A wins first.
REQ-007 COLLECT: des_data_in/des_write_in SHALL combinationally equal data/write of the granted sender. Those of the other sender are ignored. In all other states des_write_in=0.
REQ-008 COLLECT SHALL count granted write strobes in a 4-bit counter. The cycle of the 8th strobe clears the grant and moves to WAIT_READY.
REQ-009 Dropping req mid-COLLECT SHALL NOT release the grant. Ownership ends only after 8 bits.
REQ-010 WAIT_READY: on the first cycle des_data_ready=1, capture des_data into byte_out and the owner into src_out, set des_ack=1, and go to ACK.
REQ-011 ACK: hold des_ack=1 for ACK_HOLD cycles total, then clear it and go to DRAIN.
REQ-012 DRAIN: wait for des_data_ready=0, then set byte_valid=1 and go to OUTPUT.
REQ-013 OUTPUT: hold byte_valid, byte_out and src_out stable until byte_accept=1. On that cycle clear byte_valid, update the round-robin pointer to src_out, and return to IDLE.
REQ-014 Minimum latency from the 8th write to byte_valid SHALL be 2+ACK_HOLD+2 cycles, given deserializer timing of one cycle per handshake edge.
REQ-015 A req asserted outside IDLE SHALL be held pending, not lost. It is evaluated on the next IDLE cycle.
REQ-016 byte_accept outside OUTPUT SHALL be ignored.

Reset
REQ-017 Reset SHALL force: state=IDLE, grant_a=grant_b=0, des_ack=0, byte_out=0, src_out=0, byte_valid=0, bit counter=0, ACK counter=0, pointer="last=B".
REQ-018 Reset asserted in any state SHALL abort the transfer with no byte emitted. The deserializer shares the reset, so both restart empty.

Configuration
REQ-019 With ARB_FIXED_PRIO_EN defined, REQ-006 SHALL be replaced by fixed priority: A always wins a simultaneous request, and the pointer is unused.
REQ-020 Without ARB_FIXED_PRIO_EN, round-robin per REQ-006 SHALL apply.

Verification
REQ-021 req_a only, A sends bits 1,0,1,0,0,1,0,1 -> byte_out=8'hA5, src_out=0, byte_valid until byte_accept.
REQ-022 req_a and req_b together after reset, each sending 8'h3C -> first byte src_out=0, second byte src_out=1. Under ARB_FIXED_PRIO_EN with both requesting again -> A served again.
REQ-023 B toggles write_b during A's COLLECT -> B's bits do not reach des_write_in, and the A byte is intact.
REQ-024 ACK_HOLD=3 -> des_ack high exactly 3 cycles, and byte_valid appears after des_data_ready falls.
REQ-025 byte_accept held low 20 cycles -> byte_valid/byte_out stable, busy=1, new req not granted until accept.
REQ-026 reset pulsed after 4 bits in COLLECT -> all outputs at reset values next cycle, and the next full byte is received correctly.
